// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: compares the fetch-predicted next-PC with the
// resolved next-PC, holds a redirect to fetch on mismatch and counts outcomes.
module branch_resolve #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [63:0]      ex_pc,
  input  logic [63:0]      ex_predpc,
  input  logic             ex_is_ctrl,
  input  logic             ex_taken,
  input  logic [63:0]      ex_target,
  input  logic             commit_flush,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             flush_fd,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state;
  logic [63:0] actual_next;
  logic        mispredict_now;
  logic        ctrl_now;

  assign actual_next    = (ex_is_ctrl && ex_taken) ? ex_target : ex_pc + 64'd4;
  assign mispredict_now = (state == IDLE) && ex_valid && !commit_flush &&
                          (ex_predpc != actual_next);
  assign ctrl_now       = (state == IDLE) && ex_valid && ex_is_ctrl && !commit_flush;
  // Wrong-path F/D contents die in the detect cycle and for the whole redirect hold.
  assign flush_fd       = mispredict_now || (state == PENDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 64'd0;
      ctrl_cnt       <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ctrl_now) ctrl_cnt <= ctrl_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (mispredict_now) begin
            state          <= PENDING;
            redirect_valid <= 1'b1;
            redirect_pc    <= actual_next;
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
          end
        end
        PENDING: begin
          // An older flush supersedes the redirect just like an accept does.
          if (commit_flush || redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized
// traffic checked against a behavioural next-PC/redirect model.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [63:0] ex_predpc;
  logic        ex_is_ctrl;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        commit_flush;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush_fd;
  logic [31:0] ctrl_cnt;
  logic [31:0] mispredict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what the block should be doing, in terms of outstanding redirect.
  bit          m_pend;
  logic [63:0] m_rpc;
  logic [31:0] m_ctrl;
  logic [31:0] m_mis;

  branch_resolve #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_predpc(ex_predpc), .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken),
    .ex_target(ex_target), .commit_flush(commit_flush),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_fd(flush_fd), .ctrl_cnt(ctrl_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_next();
    return (ex_is_ctrl && ex_taken) ? ex_target : ex_pc + 64'd4;
  endfunction

  function automatic logic exp_flush();
    if (m_pend) return 1'b1;
    return ex_valid && !commit_flush && (ex_predpc != exp_next());
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] pred,
                       input logic ctrl, input logic tk, input logic [63:0] tgt,
                       input logic cf, input logic rdy);
    ex_valid = v; ex_pc = pc; ex_predpc = pred; ex_is_ctrl = ctrl;
    ex_taken = tk; ex_target = tgt; commit_flush = cf; redirect_ready = rdy;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  // Advances one clock and moves the model along with it.
  task automatic clock_edge();
    bit          n_pend = m_pend;
    logic [63:0] n_rpc  = m_rpc;
    logic [31:0] n_ctrl = m_ctrl;
    logic [31:0] n_mis  = m_mis;
    if (reset) begin
      n_pend = 0; n_rpc = 64'd0; n_ctrl = 32'd0; n_mis = 32'd0;
    end else if (m_pend) begin
      if (commit_flush || redirect_ready) n_pend = 0;
    end else if (ex_valid && !commit_flush) begin
      if (ex_is_ctrl) n_ctrl = m_ctrl + 32'd1;
      if (ex_predpc != exp_next()) begin
        n_pend = 1; n_rpc = exp_next(); n_mis = m_mis + 32'd1;
      end
    end
    @(posedge clk);
    m_pend = n_pend; m_rpc = n_rpc; m_ctrl = n_ctrl; m_mis = n_mis;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    clock_edge();
    clock_edge();
    n_tests++;
    if ({redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt} !== {1'b0, 64'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got rv=%b pc=%h cc=%h mc=%h, want all zero",
               redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt);
    end
    n_tests++;
    if (flush_fd !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_flush: got %b want 0", flush_fd);
    end
    reset = 1'b0;
  endtask

  task automatic test_seq_predict();
    drive(1'b1, 64'h8000_0000, 64'h8000_0004, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    n_tests++;
    if (flush_fd !== 1'b0) begin
      n_fail++; $display("[TB] FAIL seq_flush: got %b want 0", flush_fd);
    end
    clock_edge();
    drive_idle();
    n_tests++;
    if ({redirect_valid, ctrl_cnt, mispredict_cnt} !== {1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL seq_state: got rv=%b cc=%0d mc=%0d want 0/0/0",
               redirect_valid, ctrl_cnt, mispredict_cnt);
    end
  endtask

  task automatic test_taken_mispredict();
    drive(1'b1, 64'h8000_0010, 64'h8000_0014, 1'b1, 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    n_tests++;
    if (flush_fd !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mispredict_flush: got %b want 1", flush_fd);
    end
    clock_edge();
    drive_idle();
    n_tests++;
    if ({redirect_valid, redirect_pc, mispredict_cnt, ctrl_cnt} !==
        {1'b1, 64'h8000_0100, 32'd1, 32'd1}) begin
      n_fail++;
      $display("[TB] FAIL mispredict_redirect: got rv=%b pc=%h mc=%0d cc=%0d want 1/8000_0100/1/1",
               redirect_valid, redirect_pc, mispredict_cnt, ctrl_cnt);
    end
  endtask

  task automatic test_held_redirect();
    for (int i = 0; i < 3; i++) begin
      drive(1'(i % 2 == 0), 64'h8000_0200, 64'h1234, 1'b1, 1'b1, 64'h9000_0000, 1'b0, 1'b0);
      n_tests++;
      if (flush_fd !== 1'b1) begin
        n_fail++; $display("[TB] FAIL held_flush[%0d]: got %b want 1", i, flush_fd);
      end
      clock_edge();
      n_tests++;
      if ({redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt} !==
          {1'b1, 64'h8000_0100, 32'd1, 32'd1}) begin
        n_fail++;
        $display("[TB] FAIL held_redirect[%0d]: got rv=%b pc=%h cc=%0d mc=%0d want 1/8000_0100/1/1",
                 i, redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt);
      end
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++;
    if (flush_fd !== 1'b1) begin
      n_fail++; $display("[TB] FAIL accept_flush: got %b want 1", flush_fd);
    end
    clock_edge();
    drive_idle();
    n_tests++;
    if ({redirect_valid, flush_fd} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL accept_idle: got rv=%b flush=%b want 0/0", redirect_valid, flush_fd);
    end
  endtask

  task automatic test_backward_correct();
    drive(1'b1, 64'h8000_0100, 64'h8000_0000, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 1'b0);
    n_tests++;
    if (flush_fd !== 1'b0) begin
      n_fail++; $display("[TB] FAIL backward_flush: got %b want 0", flush_fd);
    end
    clock_edge();
    drive_idle();
    n_tests++;
    if ({redirect_valid, ctrl_cnt, mispredict_cnt} !== {1'b0, 32'd2, 32'd1}) begin
      n_fail++;
      $display("[TB] FAIL backward_counts: got rv=%b cc=%0d mc=%0d want 0/2/1",
               redirect_valid, ctrl_cnt, mispredict_cnt);
    end
  endtask

  task automatic test_commit_flush();
    drive(1'b1, 64'h8000_0300, 64'h0, 1'b1, 1'b1, 64'h8000_0400, 1'b1, 1'b0);
    n_tests++;
    if (flush_fd !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cf_suppress_flush: got %b want 0", flush_fd);
    end
    clock_edge();
    drive_idle();
    n_tests++;
    if ({redirect_valid, ctrl_cnt, mispredict_cnt} !== {1'b0, 32'd2, 32'd1}) begin
      n_fail++;
      $display("[TB] FAIL cf_suppress_state: got rv=%b cc=%0d mc=%0d want 0/2/1",
               redirect_valid, ctrl_cnt, mispredict_cnt);
    end
    drive(1'b1, 64'h8000_0500, 64'h0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    clock_edge();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    n_tests++;
    if ({redirect_valid, redirect_pc, flush_fd} !== {1'b1, 64'h8000_0504, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL cf_pending_entry: got rv=%b pc=%h flush=%b want 1/8000_0504/1",
               redirect_valid, redirect_pc, flush_fd);
    end
    clock_edge();
    drive_idle();
    n_tests++;
    if ({redirect_valid, flush_fd, mispredict_cnt} !== {1'b0, 1'b0, 32'd2}) begin
      n_fail++;
      $display("[TB] FAIL cf_pending_drop: got rv=%b flush=%b mc=%0d want 0/0/2",
               redirect_valid, flush_fd, mispredict_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [63:0] pc, tgt, pred;
      logic        ctrl, tk;
      pc   = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      tgt  = {$urandom, $urandom};
      ctrl = 1'($urandom_range(0, 1));
      tk   = 1'($urandom_range(0, 1));
      pred = (ctrl && tk) ? tgt : pc + 64'd4;
      if ($urandom_range(0, 3) == 0) pred = pred ^ (64'd1 << $urandom_range(0, 63));
      drive(1'($urandom_range(0, 3) != 0), pc, pred, ctrl, tk, tgt,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
      n_tests++;
      if (flush_fd !== exp_flush()) begin
        n_fail++;
        $display("[TB] FAIL rand_flush[%0d]: got %b want %b", i, flush_fd, exp_flush());
      end
      clock_edge();
      n_tests++;
      if ({redirect_valid, ctrl_cnt, mispredict_cnt} !== {m_pend, m_ctrl, m_mis} ||
          (m_pend && redirect_pc !== m_rpc)) begin
        n_fail++;
        $display("[TB] FAIL rand_state[%0d]: got rv=%b pc=%h cc=%0d mc=%0d want %b/%h/%0d/%0d",
                 i, redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt,
                 m_pend, m_rpc, m_ctrl, m_mis);
      end
    end
  endtask

  task automatic test_counter_wrap();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    clock_edge();
    force dut.ctrl_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.ctrl_cnt;
    m_ctrl = 32'hFFFF_FFFF;
    drive(1'b1, 64'h8000_0000, 64'h8000_0004, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    clock_edge();
    drive_idle();
    n_tests++;
    if ({ctrl_cnt, redirect_valid} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL ctrl_wrap: got cc=%h rv=%b want 0/0", ctrl_cnt, redirect_valid);
    end
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 64'h8000_0600, 64'h0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    clock_edge();
    n_tests++;
    if (redirect_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rp_enter: got rv=%b want 1", redirect_valid);
    end
    drive_idle();
    reset = 1'b1;
    #1;
    clock_edge();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt, flush_fd} !==
        {1'b0, 64'd0, 32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL rp_cleared: got rv=%b pc=%h cc=%0d mc=%0d flush=%b want all zero",
               redirect_valid, redirect_pc, ctrl_cnt, mispredict_cnt, flush_fd);
    end
  endtask

  initial begin
    m_pend = 0; m_rpc = 64'd0; m_ctrl = 32'd0; m_mis = 32'd0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_seq_predict();
    test_taken_mispredict();
    test_held_redirect();
    test_backward_correct();
    test_commit_flush();
    test_random();
    test_counter_wrap();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
